// File: rtl/bias_pkg.sv
// Shared types and saturating helpers for the bias weight table.
// Weight width is fixed here so every file agrees on weight_t.
package bias_pkg;

    localparam int WEIGHT_W = 2;

    typedef logic signed [WEIGHT_W-1:0] weight_t;

    localparam weight_t WMAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam weight_t WMIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam weight_t WONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    function automatic weight_t sat_inc(input weight_t w);
        weight_t r;
        if (w == WMAX) begin
            r = WMAX;
        end else begin
            r = w + WONE;
        end
        return r;
    endfunction

    function automatic weight_t sat_dec(input weight_t w);
        weight_t r;
        if (w == WMIN) begin
            r = WMIN;
        end else begin
            r = w - WONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/bias_inflight_fifo.sv
// Ordered queue of in-flight predictions: {table index, weight seen at lookup}.
// Clear has priority over push and pop in the same cycle.
module bias_inflight_fifo
    import bias_pkg::*;
#(
    parameter int INFLIGHT = 4,
    parameter int IDX_W    = 10,
    parameter int PTR_W    = $clog2(INFLIGHT),
    parameter int CNT_W    = $clog2(INFLIGHT) + 32'sd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_idx_i,
    input  weight_t          push_w_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [IDX_W-1:0] head_idx_o,
    output weight_t          head_w_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] idx_q [INFLIGHT];
    weight_t          w_q   [INFLIGHT];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o     = (cnt_q == CNT_W'(INFLIGHT));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign head_idx_o = idx_q[rd_ptr_q];
    assign head_w_o   = w_q[rd_ptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage, written at the tail on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < INFLIGHT; i++) begin
                idx_q[i] <= '0;
                w_q[i]   <= '0;
            end
        end else if (do_push_s && !clear_i) begin
            idx_q[wr_ptr_q] <= push_idx_i;
            w_q[wr_ptr_q]   <= push_w_i;
        end
    end

endmodule

// File: rtl/bias_weight_table_pipe.sv
// Bias weight table: reset-time clear sweep, one-cycle lookup, in-flight queue, saturating training.
// Optional macro BIAS_BYPASS_EN forwards a same-cycle training result to a colliding lookup.
module bias_weight_table_pipe
    import bias_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pred_valid,
    input  logic [IDX_W-1:0]    pred_index,
    output logic                pred_ready,
    output logic                wt_valid,
    output logic [WEIGHT_W-1:0] pred_weight,
    output logic                pred_taken,
    input  logic                res_valid,
    input  logic                res_taken,
    input  logic                flush,
    output logic                res_err,
    output logic                busy_init
);

    localparam int               CNT_W    = $clog2(INFLIGHT) + 32'sd1;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    weight_t          table_q [DEPTH];
    fsm_e             state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
    logic             wt_valid_q, wt_valid_d;
    weight_t          pred_weight_q, pred_weight_d;
    logic             pred_taken_q, pred_taken_d;
    logic             res_err_q, res_err_d;
    logic             busy_init_q, busy_init_d;

    logic             run_s;
    logic             accept_s;
    logic             push_s;
    logic             resolve_s;
    weight_t          upd_w_s;
    weight_t          lookup_w_s;
    logic             tbl_we_s;
    logic [IDX_W-1:0] tbl_widx_s;
    weight_t          tbl_wdata_s;

    logic [IDX_W-1:0] head_idx_s;
    weight_t          head_w_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    bias_inflight_fifo #(
        .INFLIGHT (INFLIGHT),
        .IDX_W    (IDX_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_s),
        .push_idx_i (pred_index),
        .push_w_i   (lookup_w_s),
        .pop_i      (resolve_s),
        .clear_i    (flush),
        .head_idx_o (head_idx_s),
        .head_w_o   (head_w_s),
        .count_o    (fifo_count_s),
        .full_o     (fifo_full_s),
        .empty_o    (fifo_empty_s)
    );

    // Handshake and training decode; no pop credit is given to a same-cycle lookup
    always_comb begin
        run_s      = (state_q == RUN);
        pred_ready = run_s && !flush && (fifo_count_s < CNT_W'(INFLIGHT));
        accept_s   = pred_valid && pred_ready;
        push_s     = accept_s && !fifo_full_s;
        resolve_s  = run_s && res_valid && !fifo_empty_s;
        if (res_taken) begin
            upd_w_s = sat_inc(head_w_s);
        end else begin
            upd_w_s = sat_dec(head_w_s);
        end
    end

    // Lookup value: stored weight, or the same-cycle training result when bypass is built in
    always_comb begin
        lookup_w_s = table_q[pred_index];
`ifdef BIAS_BYPASS_EN
        if (resolve_s && (head_idx_s == pred_index)) begin
            lookup_w_s = upd_w_s;
        end else begin
            lookup_w_s = table_q[pred_index];
        end
`endif
    end

    // Single table write port: clear sweep during INIT, training writes during RUN
    always_comb begin
        tbl_we_s    = 1'b0;
        tbl_widx_s  = clr_ptr_q;
        tbl_wdata_s = '0;
        if (state_q == INIT) begin
            tbl_we_s    = 1'b1;
            tbl_widx_s  = clr_ptr_q;
            tbl_wdata_s = '0;
        end else begin
            tbl_we_s    = resolve_s;
            tbl_widx_s  = head_idx_s;
            tbl_wdata_s = upd_w_s;
        end
    end

    // FSM next-state: sweep every entry once, then run
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            INIT: begin
                clr_ptr_d = clr_ptr_q + IDX_ONE;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    state_d = INIT;
                end
            end
            RUN: begin
                state_d   = RUN;
                clr_ptr_d = clr_ptr_q;
            end
            default: begin
                state_d   = INIT;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Output next-state; the weight and hint hold between accepts
    always_comb begin
        wt_valid_d    = accept_s;
        pred_weight_d = pred_weight_q;
        pred_taken_d  = pred_taken_q;
        if (accept_s) begin
            pred_weight_d = lookup_w_s;
            pred_taken_d  = !lookup_w_s[WEIGHT_W-1];
        end else begin
            pred_weight_d = pred_weight_q;
            pred_taken_d  = pred_taken_q;
        end
        res_err_d   = run_s && res_valid && fifo_empty_s;
        busy_init_d = (state_q == INIT);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT;
            clr_ptr_q     <= '0;
            wt_valid_q    <= 1'b0;
            pred_weight_q <= '0;
            pred_taken_q  <= 1'b0;
            res_err_q     <= 1'b0;
            busy_init_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wt_valid_q    <= wt_valid_d;
            pred_weight_q <= pred_weight_d;
            pred_taken_q  <= pred_taken_d;
            res_err_q     <= res_err_d;
            busy_init_q   <= busy_init_d;
        end
    end

    // Weight storage; contents are defined by the INIT sweep rather than by reset
    always_ff @(posedge clk) begin
        if (tbl_we_s) begin
            table_q[tbl_widx_s] <= tbl_wdata_s;
        end
    end

    assign wt_valid    = wt_valid_q;
    assign pred_weight = pred_weight_q;
    assign pred_taken  = pred_taken_q;
    assign res_err     = res_err_q;
    assign busy_init   = busy_init_q;

endmodule
